// File: rtl/scm_rw_arbiter_pkg.sv
// Shared helpers for the SCM read/write arbiter: port-ID width calculation and
// a default-sized port ID type.
package scm_arb_pkg;

    // Width of a port index; at least one bit so a 1-port build still has a
    // legal vector.
    function automatic int unsigned clog2_ports(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEFAULT_N_PORTS = 4;
    localparam int unsigned DEFAULT_ID_W    = clog2_ports(DEFAULT_N_PORTS);

    typedef logic [DEFAULT_ID_W-1:0] port_id_t;

endpackage

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr wins (wrapping), and
// ptr moves to one past the winner whenever a grant is issued.
module scm_rr_arbiter
    import scm_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N-1:0]                req,
    output logic [N-1:0]                gnt,
    output logic [clog2_ports(N)-1:0]   idx,
    output logic                        valid
);

    localparam int unsigned ID_W = clog2_ports(N);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] cand;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a value held (no latch).
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (valid) begin
            ptr_d = (32'(idx) == N - 1) ? '0 : idx + ID_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on
    // the clock edge, so it only takes effect at the end of the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scm_rw_arbiter.sv
// Shares one 1R1W byte-enable SCM between N_PORTS requesters; reads and writes
// are arbitrated independently and read data returns one cycle after grant.
module scm_rw_arbiter
    import scm_arb_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_PORTS-1:0]                     req_i,
    input  logic [N_PORTS-1:0]                     we_i,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [N_PORTS-1:0][NUM_BYTE-1:0]       be_i,
    output logic [N_PORTS-1:0]                     gnt_o,
    output logic [N_PORTS-1:0]                     r_valid_o,
    output logic [DATA_WIDTH-1:0]                  r_rdata_o,
    output logic                                   scm_re_o,
    output logic [ADDR_WIDTH-1:0]                  scm_raddr_o,
    input  logic [DATA_WIDTH-1:0]                  scm_rdata_i,
    output logic                                   scm_we_o,
    output logic [ADDR_WIDTH-1:0]                  scm_waddr_o,
    output logic [DATA_WIDTH-1:0]                  scm_wdata_o,
    output logic [NUM_BYTE-1:0]                    scm_be_o
);

    localparam int unsigned ID_W = clog2_ports(N_PORTS);

    logic [N_PORTS-1:0] rd_req;
    logic [N_PORTS-1:0] wr_req;
    logic [N_PORTS-1:0] rd_gnt;
    logic [N_PORTS-1:0] wr_gnt;
    logic [ID_W-1:0]    rd_idx;
    logic [ID_W-1:0]    wr_idx;
    logic               rd_valid;
    logic               wr_valid;

    logic [ID_W-1:0]    rid_q;
    logic [ID_W-1:0]    rid_d;
    logic               rvld_q;
    logic               rvld_d;

    assign rd_req = req_i & ~we_i;
    assign wr_req = req_i & we_i;

    scm_rr_arbiter #(
        .N     (N_PORTS)
    ) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt),
        .idx   (rd_idx),
        .valid (rd_valid)
    );

    scm_rr_arbiter #(
        .N     (N_PORTS)
    ) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .gnt   (wr_gnt),
        .idx   (wr_idx),
        .valid (wr_valid)
    );

    assign gnt_o = rd_gnt | wr_gnt;

    // Arbiter index is 0 with no winner, so idle address/data mux from port 0.
    assign scm_re_o    = rd_valid;
    assign scm_raddr_o = addr_i[rd_idx];

    // A zero-byte-enable write is granted but never toggles the macro.
    assign scm_we_o    = wr_valid & (|be_i[wr_idx]);
    assign scm_waddr_o = addr_i[wr_idx];
    assign scm_wdata_o = wdata_i[wr_idx];
    assign scm_be_o    = wr_valid ? be_i[wr_idx] : '0;

    assign rvld_d = rd_valid;
    assign rid_d  = rd_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvld_q <= 1'b0;
            rid_q  <= '0;
        end else begin
            rvld_q <= rvld_d;
            rid_q  <= rid_d;
        end
    end

    // Gated by rst_n so a read granted just before reset is dropped.
    always_comb begin
        r_valid_o = '0;
        if (rvld_q && rst_n) begin
            r_valid_o[rid_q] = 1'b1;
        end
    end

    assign r_rdata_o = scm_rdata_i;

endmodule

// File: tb/tb_scm_rw_arbiter.sv
// Self-checking bench for scm_rw_arbiter: SCM macro model, behavioural
// round-robin/memory reference, scoreboard for returned read data.
module tb_scm_rw_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NB    = 4;
    localparam int DEPTH = 32;
    localparam int IDW   = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NP-1:0]             req_i;
    logic [NP-1:0]             we_i;
    logic [NP-1:0][AW-1:0]     addr_i;
    logic [NP-1:0][DW-1:0]     wdata_i;
    logic [NP-1:0][NB-1:0]     be_i;
    logic [NP-1:0]             gnt_o;
    logic [NP-1:0]             r_valid_o;
    logic [DW-1:0]             r_rdata_o;
    logic                      scm_re_o;
    logic [AW-1:0]             scm_raddr_o;
    logic [DW-1:0]             scm_rdata_i;
    logic                      scm_we_o;
    logic [AW-1:0]             scm_waddr_o;
    logic [DW-1:0]             scm_wdata_o;
    logic [NB-1:0]             scm_be_o;

    always #5 clk = ~clk;

    scm_rw_arbiter #(
        .N_PORTS    (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BYTE   (NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .scm_re_o    (scm_re_o),
        .scm_raddr_o (scm_raddr_o),
        .scm_rdata_i (scm_rdata_i),
        .scm_we_o    (scm_we_o),
        .scm_waddr_o (scm_waddr_o),
        .scm_wdata_o (scm_wdata_o),
        .scm_be_o    (scm_be_o)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 3) return 32'hAABBCCDD;
        if (i == 5) return 32'hDEADBEEF;
        return 32'h1000_0000 + DW'(i) * 32'h0101_0101;
    endfunction

    // SCM macro model: write commits at the edge, read address registered,
    // data presented the following cycle (write-first on a collision).
    bit            mem_loaded;
    bit [DW-1:0]   scm_mem [DEPTH];
    bit [AW-1:0]   rd_addr_q;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) scm_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (scm_we_o) begin
                for (int b = 0; b < NB; b++)
                    if (scm_be_o[b]) scm_mem[scm_waddr_o][b*8 +: 8] <= scm_wdata_o[b*8 +: 8];
            end
            if (scm_re_o) rd_addr_q <= scm_raddr_o;
        end
    end

    assign scm_rdata_i = scm_mem[rd_addr_q];

    // Reference model state.
    typedef struct {
        bit            active;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NB-1:0] be;
    } req_t;

    typedef struct {
        int            cyc;
        int            port;
        logic [DW-1:0] data;
    } rexp_t;

    req_t          pend [NP];
    rexp_t         sb [$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            rd_ptr;
    int            wr_ptr;
    int            total;
    int            bad;
    int            cyc;
    bit            done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input bit [NP-1:0] cont, input int ptr);
        for (int k = 0; k < NP; k++)
            if (cont[IDW'((ptr + k) % NP)]) return (ptr + k) % NP;
        return -1;
    endfunction

    task automatic issue(input int p, input bit we, input int addr,
                         input logic [DW-1:0] wd, input logic [NB-1:0] be);
        pend[p].active = 1'b1;
        pend[p].we     = we;
        pend[p].addr   = AW'(addr);
        pend[p].wdata  = wd;
        pend[p].be     = be;
    endtask

    // One clock cycle: drive held requests, check combinational outputs
    // against the model, push expected read returns, advance the model.
    task automatic step(input bit rst_val);
        bit [NP-1:0]   rc;
        bit [NP-1:0]   wc;
        bit [NP-1:0]   eg;
        int            rw;
        int            ww;
        logic [DW-1:0] rdexp;
        rexp_t         e;
        @(posedge clk);
        #1;
        rst_n = rst_val;
        for (int p = 0; p < NP; p++) begin
            req_i[p]   = pend[p].active;
            we_i[p]    = pend[p].we;
            addr_i[p]  = pend[p].addr;
            wdata_i[p] = pend[p].wdata;
            be_i[p]    = pend[p].be;
            rc[p]      = pend[p].active & ~pend[p].we;
            wc[p]      = pend[p].active & pend[p].we;
        end
        rw = pick(rc, rd_ptr);
        ww = pick(wc, wr_ptr);
        eg = '0;
        if (rw >= 0) eg[IDW'(rw)] = 1'b1;
        if (ww >= 0) eg[IDW'(ww)] = 1'b1;
        @(negedge clk);
        check("gnt", 64'(gnt_o), 64'(eg));
        check("scm_re", 64'(scm_re_o), 64'(rw >= 0));
        if (rw >= 0) check("scm_raddr", 64'(scm_raddr_o), 64'(pend[rw].addr));
        check("scm_we", 64'(scm_we_o), 64'(ww >= 0 && pend[ww].be != 0));
        check("scm_be", 64'(scm_be_o), (ww >= 0) ? 64'(pend[ww].be) : 64'd0);
        if (ww >= 0) begin
            check("scm_waddr", 64'(scm_waddr_o), 64'(pend[ww].addr));
            check("scm_wdata", 64'(scm_wdata_o), 64'(pend[ww].wdata));
        end
        if (rw >= 0 && rst_val) begin
            rdexp = ref_mem[pend[rw].addr];
            if (ww >= 0 && pend[ww].addr == pend[rw].addr)
                for (int b = 0; b < NB; b++)
                    if (pend[ww].be[b]) rdexp[b*8 +: 8] = pend[ww].wdata[b*8 +: 8];
            e.cyc  = cyc;
            e.port = rw;
            e.data = rdexp;
            sb.push_back(e);
        end
        if (ww >= 0)
            for (int b = 0; b < NB; b++)
                if (pend[ww].be[b]) ref_mem[pend[ww].addr][b*8 +: 8] = pend[ww].wdata[b*8 +: 8];
        if (!rst_val) begin
            rd_ptr = 0;
            wr_ptr = 0;
        end else begin
            if (rw >= 0) rd_ptr = (rw + 1) % NP;
            if (ww >= 0) wr_ptr = (ww + 1) % NP;
        end
        if (rw >= 0) pend[rw].active = 1'b0;
        if (ww >= 0) pend[ww].active = 1'b0;
    endtask

    function automatic bit any_pending();
        for (int p = 0; p < NP; p++) if (pend[p].active) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: the oldest expected return is due exactly one cycle after its
    // grant; r_valid_o must be zero in every other cycle.
    always @(negedge clk) begin : monitor
        rexp_t         r;
        bit [NP-1:0]   ev;
        logic [DW-1:0] ed;
        if (!done) begin
            ev = '0;
            ed = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                r = sb.pop_front();
                if (rst_n) begin
                    ev[IDW'(r.port)] = 1'b1;
                    ed = r.data;
                end
            end
            check("r_valid", 64'(r_valid_o), 64'(ev));
            if (ev != 0) check("r_rdata", 64'(r_rdata_o), 64'(ed));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        for (int p = 0; p < NP; p++) pend[p].active = 1'b0;
        repeat (3) step(1'b0);

        // Single read from port 2, addr 5.
        issue(2, 1'b0, 5, '0, '0);
        step(1'b1);
        step(1'b1);

        // All ports reading continuously from reset.
        step(1'b0);
        repeat (12) begin
            for (int p = 0; p < NP; p++)
                if (!pend[p].active) issue(p, 1'b0, $urandom_range(0, DEPTH - 1), '0, '0);
            step(1'b1);
        end
        for (int n = 0; n < 8 && any_pending(); n++) step(1'b1);
        step(1'b1);

        // Same-address write (partial bytes) and read in one cycle.
        step(1'b0);
        issue(1, 1'b1, 3, 32'h11223344, 4'b0101);
        issue(0, 1'b0, 3, '0, '0);
        step(1'b1);
        step(1'b1);

        // Zero byte-enable write, then contested writes, then read back.
        issue(3, 1'b1, 7, 32'hFFFF_FFFF, 4'b0000);
        step(1'b1);
        issue(0, 1'b1, 8, 32'h0808_0808, 4'b1111);
        issue(3, 1'b1, 9, 32'h0909_0909, 4'b1111);
        step(1'b1);
        step(1'b1);
        issue(2, 1'b0, 7, '0, '0);
        step(1'b1);
        issue(1, 1'b0, 8, '0, '0);
        step(1'b1);
        step(1'b1);

        // Reset in the cycle after a read grant; then ports 1 and 3 contend.
        issue(0, 1'b0, 4, '0, '0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        issue(1, 1'b0, 10, '0, '0);
        issue(3, 1'b0, 11, '0, '0);
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Ports 0 and 1 always busy with mixed reads/writes on a few addresses.
        repeat (24) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p].active)
                    issue(p, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                          $urandom, NB'($urandom_range(0, 15)));
            step(1'b1);
        end

        // Random traffic on all ports with occasional reset pulses.
        repeat (400) begin
            for (int p = 0; p < NP; p++)
                if (!pend[p].active && $urandom_range(0, 1) == 1)
                    issue(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                          $urandom, NB'($urandom_range(0, 15)));
            step($urandom_range(0, 49) != 0);
        end
        for (int n = 0; n < 16 && any_pending(); n++) step(1'b1);
        step(1'b1);
        step(1'b1);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
